// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: sel encoding, redirect FSM states and default exception vector
package pc_redirect_pkg;
  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BEQ  = 3'd1;
  localparam logic [2:0] SEL_BNE  = 3'd2;
  localparam logic [2:0] SEL_JUMP = 3'd3;
  localparam logic [2:0] SEL_JR   = 3'd4;
  localparam logic [2:0] SEL_EXC  = 3'd5;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;
  typedef enum logic {ST_RUN, ST_HOLD} state_t;
endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: resolves taken/target for the next PC; misaligned redirects
// become the exception vector only when PC_ALIGN_CHECK_EN is defined.
module pc_target_sel
  import pc_redirect_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INC = 4,
  parameter logic [WIDTH-1:0] EXC = '0
) (
  input  logic [2:0]       sel,
  input  logic             zero,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] target,
  output logic             taken,
  output logic             misalign
);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] MASK = WIDTH'(INC - 1);
`else
  localparam logic [WIDTH-1:0] MASK = '0;
`endif
  logic [WIDTH-1:0] raw;
  assign raw = sel == SEL_JUMP ? jump_target :
               sel == SEL_JR   ? jr_target :
               sel == SEL_EXC  ? EXC : branch_target;
  assign taken = sel == SEL_BEQ ? zero :
                 sel == SEL_BNE ? !zero :
                 (sel == SEL_JUMP || sel == SEL_JR || sel == SEL_EXC);
  assign misalign = taken && |(raw & MASK);
  assign target = !taken ? pc_plus : misalign ? EXC : raw;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: PC register with stall-buffered redirects and flush pulse.
// Optional alignment check enabled by defining PC_ALIGN_CHECK_EN.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int INC = 4,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       sel,
  input  logic             zero,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             flush,
  output logic             redirect_pending,
  output logic             misalign
);
  localparam logic [WIDTH-1:0] EXC = WIDTH'(EXC_VECTOR);
  state_t state, state_nxt;
  logic [WIDTH-1:0] target, pending;
  logic taken, mis, pend_mis, exc_sel;
  assign pc_plus = pc + WIDTH'(INC);
  assign exc_sel = sel == SEL_EXC;
  assign redirect_pending = state == ST_HOLD;
  pc_target_sel #(.WIDTH(WIDTH), .INC(INC), .EXC(EXC)) u_sel (
    .sel(sel), .zero(zero), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .pc_plus(pc_plus),
    .target(target), .taken(taken), .misalign(mis)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = state == ST_RUN ? (stall && taken ? ST_HOLD : ST_RUN) : (stall ? ST_HOLD : ST_RUN);
  end
  always_ff @(posedge clk) state <= rst ? ST_RUN : state_nxt;
  // an exception arriving during HOLD supersedes the buffered redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pending <= '0;
      pend_mis <= 1'b0;
      flush <= 1'b0;
      misalign <= 1'b0;
    end else begin
      flush <= 1'b0;
      misalign <= 1'b0;
      if (state == ST_RUN) begin
        if (!stall) begin
          pc <= target;
          flush <= taken;
          misalign <= mis;
        end else if (taken) begin
          pending <= target;
          pend_mis <= mis;
        end
      end else if (stall) begin
        if (exc_sel) begin
          pending <= EXC;
          pend_mis <= 1'b0;
        end
      end else begin
        pc <= exc_sel ? EXC : pending;
        flush <= 1'b1;
        misalign <= !exc_sel && pend_mis;
      end
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed stimulus, cycle model comparison and literal checks
module tb_pc_redirect_unit;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] EXC = 32'h80;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, zero = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] pc, pc_plus;
  logic flush, redirect_pending, misalign;
  int checks = 0, errors = 0;
  logic [31:0] m_pc = '0, m_pend = '0;
  logic m_hold = 1'b0, m_flush = 1'b0, m_mis = 1'b0, m_pbad = 1'b0, m_valid = 1'b0;

  pc_redirect_unit #(.WIDTH(32), .RESET_PC(RPC), .INC(4), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .sel(sel), .zero(zero),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .pc(pc), .pc_plus(pc_plus), .flush(flush), .redirect_pending(redirect_pending),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit f_taken(input logic [2:0] s, input logic z);
    return s == 3'd1 ? z : s == 3'd2 ? !z : (s >= 3'd3 && s <= 3'd5);
  endfunction
  function automatic logic [31:0] f_dest(input logic [2:0] s);
    return s == 3'd3 ? jump_target : s == 3'd4 ? jr_target : s == 3'd5 ? EXC : branch_target;
  endfunction
  function automatic bit f_bad(input logic [2:0] s, input logic z);
    return ALIGN && f_taken(s, z) && (f_dest(s) % 4 != 0);
  endfunction
  function automatic logic [31:0] f_next(input logic [2:0] s, input logic z);
    return !f_taken(s, z) ? m_pc + 32'd4 : f_bad(s, z) ? EXC : f_dest(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_pc <= RPC;
      m_hold <= 1'b0;
      m_flush <= 1'b0;
      m_mis <= 1'b0;
    end else if (!m_hold) begin
      m_flush <= !stall && f_taken(sel, zero);
      m_mis <= !stall && f_bad(sel, zero);
      if (!stall) m_pc <= f_next(sel, zero);
      else if (f_taken(sel, zero)) begin
        m_hold <= 1'b1;
        m_pend <= f_next(sel, zero);
        m_pbad <= f_bad(sel, zero);
      end
    end else if (stall) begin
      m_flush <= 1'b0;
      m_mis <= 1'b0;
      if (sel == 3'd5) begin
        m_pend <= EXC;
        m_pbad <= 1'b0;
      end
    end else begin
      m_hold <= 1'b0;
      m_flush <= 1'b1;
      m_pc <= sel == 3'd5 ? EXC : m_pend;
      m_mis <= sel != 3'd5 && m_pbad;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus", pc_plus, m_pc + 32'd4);
      chk("model_flush", 32'(flush), 32'(m_flush));
      chk("model_pending", 32'(redirect_pending), 32'(m_hold));
      chk("model_misalign", 32'(misalign), 32'(m_mis));
    end
  end

  task automatic drive(input logic [2:0] s, input logic st, input logic z);
    sel = s;
    stall = st;
    zero = z;
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [31:0] t);
    jump_target = t;
    drive(3'd3, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 32'h100);
    chk("reset_flush", 32'(flush), 0);
    chk("reset_pending", 32'(redirect_pending), 0);
    rst = 1'b0;
    drive(3'd0, 0, 0);
    chk("seq1", pc, 32'h104);
    drive(3'd0, 0, 0);
    chk("seq2", pc, 32'h108);
    drive(3'd0, 0, 0);
    chk("seq3", pc, 32'h10C);
    chk("seq_flush", 32'(flush), 0);
    jump_to(32'h200);
    chk("jump_pc", pc, 32'h200);
    chk("jump_flush", 32'(flush), 1);
    branch_target = 32'h400;
    drive(3'd1, 0, 1);
    chk("beq_taken_pc", pc, 32'h400);
    chk("beq_taken_flush", 32'(flush), 1);
    jump_to(32'h200);
    drive(3'd1, 0, 0);
    chk("beq_nt_pc", pc, 32'h204);
    chk("beq_nt_flush", 32'(flush), 0);
    drive(3'd2, 0, 0);
    chk("bne_taken_pc", pc, 32'h400);
    drive(3'd2, 0, 1);
    chk("bne_nt_pc", pc, 32'h404);
    drive(3'd6, 0, 0);
    chk("sel6_seq", pc, 32'h408);
    chk("sel6_flush", 32'(flush), 0);
    jump_target = 32'h800;
    jr_target = 32'h900;
    drive(3'd3, 1, 0);
    chk("stall_hold_pc", pc, 32'h408);
    chk("stall_pending", 32'(redirect_pending), 1);
    repeat (3) drive(3'd4, 1, 0);
    chk("hold_ignores_jr", pc, 32'h408);
    chk("hold_no_flush", 32'(flush), 0);
    drive(3'd0, 0, 0);
    chk("release_pc", pc, 32'h800);
    chk("release_flush", 32'(flush), 1);
    chk("release_pending", 32'(redirect_pending), 0);
    drive(3'd0, 0, 0);
    chk("flush_one_cycle", 32'(flush), 0);
    drive(3'd3, 1, 0);
    drive(3'd5, 1, 0);
    drive(3'd0, 0, 0);
    chk("hold_exc_pc", pc, 32'h80);
    chk("hold_exc_flush", 32'(flush), 1);
    drive(3'd3, 1, 0);
    drive(3'd5, 0, 0);
    chk("release_exc_pc", pc, 32'h80);
    jump_to(32'hFFFF_FFFC);
    chk("wrap_pc_plus", pc_plus, 32'h0);
    drive(3'd0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_flush", 32'(flush), 0);
    drive(3'd3, 1, 0);
    chk("pre_rst_pending", 32'(redirect_pending), 1);
    rst = 1'b1;
    drive(3'd0, 1, 0);
    rst = 1'b0;
    chk("rst_hold_pc", pc, 32'h100);
    chk("rst_hold_pending", 32'(redirect_pending), 0);
    chk("rst_hold_flush", 32'(flush), 0);
    drive(3'd0, 0, 0);
    jump_to(32'h802);
    chk("mis_pc", pc, ALIGN ? 32'h80 : 32'h802);
    chk("mis_flush", 32'(flush), 1);
    chk("mis_flag", 32'(misalign), ALIGN ? 1 : 0);
    drive(3'd0, 0, 0);
    chk("mis_one_cycle", 32'(misalign), 0);
    jump_target = 32'h806;
    drive(3'd3, 1, 0);
    drive(3'd0, 0, 0);
    chk("mis_pend_pc", pc, ALIGN ? 32'h80 : 32'h806);
    chk("mis_pend_flag", 32'(misalign), ALIGN ? 1 : 0);
    drive(3'd0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised next-PC generator that supersedes the fixed 32-bit 4-way next-PC mux.
- Owns the PC register and selects among sequential, BEQ, BNE, jump, jump-register and exception targets.
- Buffers a redirect that arrives during a stall and emits a one-cycle flush pulse to the fetch/decode pipeline registers.
- Sits between the branch/zero logic and the instruction-fetch stage.

Parameters:
- WIDTH, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INC, 4, sequential increment; must be a power of two.
- EXC_VECTOR, 32'h0000_0080, exception/trap target; truncated to WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle (hazard or memory wait).
- sel  in  3  next-PC source: 0 SEQ, 1 BEQ, 2 BNE, 3 JUMP, 4 JR, 5 EXC; 6–7 treated as SEQ.
- zero  in  1  ALU zero flag for BEQ/BNE resolution.
- branch_target  in  WIDTH  BEQ/BNE target.
- jump_target  in  WIDTH  JUMP target.
- jr_target  in  WIDTH  JR register target.
- pc  out  WIDTH  current PC (registered).
- pc_plus  out  WIDTH  pc + INC (combinational, wraps modulo 2^WIDTH).
- flush  out  1  registered one-cycle pulse; high in the first cycle pc shows a redirect target.
- redirect_pending  out  1  high while a buffered redirect waits for stall release.
- misalign  out  1  registered one-cycle misaligned-target pulse (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge; overrides every other input): pc=RESET_PC, flush=0, redirect_pending=0, misalign=0, state=RUN, pending target cleared.
- Taken condition:
  - BEQ taken iff zero=1.
  - BNE taken iff zero=0.
  - JUMP, JR and EXC always taken.
  - SEQ and not-taken branches are not redirects.
- Target: the selected source for a taken redirect, otherwise pc_plus.
- FSM has two states, RUN and HOLD.
- RUN, stall=0:
  - pc <= target; flush <= 1 iff taken.
  - Latency: the target is visible on pc one cycle after sel is sampled.
- RUN, stall=1:
  - pc holds; flush <= 0.
  - If taken: pending <= target and state <= HOLD; redirect_pending is 1 from the next cycle.
  - If not taken: no state change.
- HOLD, stall=1:
  - pc holds; flush <= 0.
  - sel=EXC overwrites pending with EXC_VECTOR.
  - All other sel values are ignored: the older buffered redirect wins.
- HOLD, stall=0:
  - pc <= pending, flush <= 1, state <= RUN, redirect_pending <= 0.
  - The current sel is ignored unless it is EXC, in which case pc <= EXC_VECTOR instead.
- flush is never high for two consecutive cycles unless two consecutive taken redirects occur with stall=0.
- Reset in HOLD discards the pending redirect; redirect_pending is 0 the cycle after.
- Wrap-around: pc = 2^WIDTH − INC with SEQ → pc = 0, flush = 0.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- With the macro defined:
  - A taken redirect whose low log2(INC) bits are non-zero is replaced by EXC_VECTOR.
  - misalign pulses 1 in the same cycle flush pulses.
  - This applies equally to a pending target on release; the check is made when the target is latched.
- Without the macro: targets are used unmodified and misalign is tied to 0. The port is always present.

Decomposition:
- Package pc_redirect_pkg holds:
  - sel encoding constants (SEL_SEQ … SEL_EXC);
  - the FSM state encoding (ST_RUN, ST_HOLD);
  - the default EXC_VECTOR constant.
- Sub-module pc_target_sel is the natural split: combinational; inputs are sel, zero, the targets and pc_plus; outputs are target and taken (plus the misalignment flag under the macro).
- The top level keeps the PC register, pending register, FSM and output registers.

Test Plan:
- Reset with RESET_PC=0x100, then 3 cycles of SEQ, no stall → pc = 0x104, 0x108, 0x10C; flush=0 throughout.
- pc=0x200, sel=BEQ, zero=1, branch_target=0x400 → next pc=0x400, flush=1 for one cycle. Same with zero=0 → pc=0x204, flush=0. BNE, zero=0 → pc=0x400.
- stall=1 with sel=JUMP, jump_target=0x800 → pc holds and redirect_pending=1. Hold stall 3 cycles while driving sel=JR, jr_target=0x900. Release → pc=0x800, flush=1, redirect_pending=0.
- In HOLD with pending=0x800, drive sel=EXC → on release pc=0x80, flush=1.
- pc=0xFFFF_FFFC, SEQ → pc=0x0, flush=0. Assert rst while in HOLD → pc=RESET_PC, redirect_pending=0, flush=0.
- With PC_ALIGN_CHECK_EN defined: JUMP to 0x802 → pc=0x80, flush=1, misalign=1 for one cycle. Without the macro: pc=0x802, misalign=0.
